// File: rtl/serdes_pkg.sv
// Shared types and constants for the serializer/deserializer pair.
package serdes_pkg;

  typedef enum logic [0:0] {
    IDLE_S  = 1'b0,
    SHIFT_S = 1'b1
  } deser_state_e;

  localparam int unsigned DEFAULT_DATA_BUS_WIDTH = 16;
  localparam int unsigned MIN_FLUSH_BITS         = 3;

endpackage

// File: rtl/deser_out_reg.sv
// Valid/ready holding register for deserialized words; drops a new word and
// pulses ovf_o when the register is occupied and not draining in that cycle.
module deser_out_reg #(
  parameter int W = 16,
  parameter int M = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic [M-1:0] load_mod_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic [M-1:0] mod_o,
  output logic         val_o,
  output logic         ovf_o
);

  logic [W-1:0] data_q, data_d;
  logic [M-1:0] mod_q, mod_d;
  logic         val_q, val_d;
  logic         ovf_q, ovf_d;

  // Load/drain/drop decision; a drain and a load may share one cycle.
  always_comb begin
    data_d = data_q;
    mod_d  = mod_q;
    val_d  = val_q;
    ovf_d  = 1'b0;
    if (load_i) begin
      if (!val_q || ready_i) begin
        data_d = load_data_i;
        mod_d  = load_mod_i;
        val_d  = 1'b1;
      end else begin
        ovf_d  = 1'b1;
      end
    end else if (val_q && ready_i) begin
      val_d = 1'b0;
    end else begin
      val_d = val_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      mod_q  <= '0;
      val_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      mod_q  <= mod_d;
      val_q  <= val_d;
      ovf_q  <= ovf_d;
    end
  end

  assign data_o = data_q;
  assign mod_o  = mod_q;
  assign val_o  = val_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/deserializer.sv
// Packs an MSB-first serial stream into W-bit words with a valid-bit count.
// Define DESERIALIZER_PARTIAL_FLUSH_EN to emit left-aligned partial bursts of 3..W-1 bits.
module deserializer
  import serdes_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = DEFAULT_DATA_BUS_WIDTH,
  parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  input  logic                      deser_data_ready_i,
  output logic                      busy_o,
  output logic                      ovf_o,
  output logic                      short_o
);

  localparam int W = DATA_BUS_WIDTH;
  localparam int M = DATA_MOD_WIDTH;
  localparam logic [M-1:0] LAST_CNT = M'(W - 1);

  deser_state_e state_q, state_d;
  logic [M-1:0] bit_cnt_q, bit_cnt_d;
  // Only W-1 history bits are kept: the W-th bit goes straight into the output word.
  logic [W-2:0] shift_buf_q, shift_buf_d;
  logic         busy_q, busy_d;
  logic         short_q, short_d;

  logic [W-1:0] shifted_s;
  logic         load_s;
  logic [W-1:0] load_data_s;
  logic [M-1:0] load_mod_s;

`ifdef DESERIALIZER_PARTIAL_FLUSH_EN
  localparam logic [M-1:0] MIN_FLUSH_CNT = M'(MIN_FLUSH_BITS);
  logic [M:0] pad_s;
`endif

  assign shifted_s = {shift_buf_q, ser_data_i};

  // Sampling FSM, bit counter and word/flush generation.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_buf_d = shift_buf_q;
    short_d     = 1'b0;
    load_s      = 1'b0;
    load_data_s = '0;
    load_mod_s  = '0;
`ifdef DESERIALIZER_PARTIAL_FLUSH_EN
    pad_s       = (M+1)'(W) - {1'b0, bit_cnt_q};
`endif
    case (state_q)
      IDLE_S: begin
        if (ser_data_val_i) begin
          state_d     = SHIFT_S;
          shift_buf_d = shifted_s[W-2:0];
          bit_cnt_d   = M'(1);
        end else begin
          state_d     = IDLE_S;
        end
      end
      SHIFT_S: begin
        if (ser_data_val_i) begin
          shift_buf_d = shifted_s[W-2:0];
          if (bit_cnt_q == LAST_CNT) begin
            load_s      = 1'b1;
            load_data_s = shifted_s;
            load_mod_s  = '0;
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d   = bit_cnt_q + M'(1);
          end
        end else begin
          state_d   = IDLE_S;
          bit_cnt_d = '0;
          if (bit_cnt_q != '0) begin
`ifdef DESERIALIZER_PARTIAL_FLUSH_EN
            if (bit_cnt_q >= MIN_FLUSH_CNT) begin
              load_s      = 1'b1;
              load_data_s = {1'b0, shift_buf_q} << pad_s;
              load_mod_s  = bit_cnt_q;
            end else begin
              short_d     = 1'b1;
            end
`else
            short_d = 1'b1;
`endif
          end else begin
            short_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE_S;
        bit_cnt_d = '0;
      end
    endcase
    busy_d = (bit_cnt_d != '0);
  end

  // Sampling state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE_S;
      bit_cnt_q   <= '0;
      shift_buf_q <= '0;
      busy_q      <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_buf_q <= shift_buf_d;
      busy_q      <= busy_d;
      short_q     <= short_d;
    end
  end

  deser_out_reg #(
    .W (W),
    .M (M)
  ) u_out_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load_s),
    .load_data_i (load_data_s),
    .load_mod_i  (load_mod_s),
    .ready_i     (deser_data_ready_i),
    .data_o      (deser_data_o),
    .mod_o       (deser_data_mod_o),
    .val_o       (deser_data_val_o),
    .ovf_o       (ovf_o)
  );

  assign busy_o  = busy_q;
  assign short_o = short_q;

endmodule
